// File: rtl/pwm_bus_slave.sv
// Memory-mapped single-channel PWM peripheral.
// Registers at BASE_ADDR: +0x0 ENABLE (bit 0), +0x4 PERIOD, +0x8 DUTY, +0xC COUNT (read-only).
// PERIOD/DUTY are double-buffered into shadows that reload only at a period wrap or on start.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   adr, cs, wr, rd    bus address and strobes (cs qualifies wr/rd, write wins over read)
//   d_in / d_out       write data / registered read data
//   pwm_out            registered PWM waveform
//   period_end         registered pulse in the last cycle of each running period
module pwm_bus_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] adr,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        pwm_out,
  output logic        period_end
);

  localparam int unsigned DW = 32;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic            enable_q;
  logic [DW-1:0]   period_q, duty_q;
  logic [DW-1:0]   period_act_q, period_act_d;
  logic [DW-1:0]   duty_act_q, duty_act_d;
  logic [DW-1:0]   count_q, count_d;
  logic            pwm_d, pend_d;

  logic [DW-1:0]   off_c;
  logic            hit_c, wr_en_c, rd_en_c;
  logic [1:0]      sel_c;
  logic [DW-1:0]   rdata_c;
  logic            wrap_c;

  // Address decode: 16-byte window, word-aligned offsets only.
  // Addresses below BASE_ADDR wrap to large offsets and fall outside the window.
  assign off_c   = adr - BASE_ADDR;
  assign hit_c   = (off_c[DW-1:4] == '0) && (off_c[1:0] == 2'b00);
  assign sel_c   = off_c[3:2];
  assign wr_en_c = cs && wr;
  assign rd_en_c = cs && rd && !wr;

  // Register file writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= 1'b0;
      period_q <= '0;
      duty_q   <= '0;
    end else if (wr_en_c && hit_c) begin
      case (sel_c)
        2'd0:    enable_q <= d_in[0];
        2'd1:    period_q <= d_in;
        2'd2:    duty_q   <= d_in;
        default: ;
      endcase
    end
  end

  // Read mux; unmapped reads return 0.
  always_comb begin
    rdata_c = '0;
    if (hit_c) begin
      case (sel_c)
        2'd0:    rdata_c = {{(DW-1){1'b0}}, enable_q};
        2'd1:    rdata_c = period_q;
        2'd2:    rdata_c = duty_q;
        default: rdata_c = count_q;
      endcase
    end
  end

  // Registered read data; holds unless a pure read is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out <= '0;
    end else if (rd_en_c) begin
      d_out <= rdata_c;
    end
  end

  // Period 0 and 1 both wrap every cycle; the <= 1 test also guards the subtraction.
  assign wrap_c = (period_act_q <= DW'(1)) || (count_q == period_act_q - DW'(1));

  // Next-state, counter, shadow reload and look-ahead output logic.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    pwm_d        = 1'b0;
    pend_d       = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable_q) begin
          state_d      = RUN;
          period_act_d = period_q;
          duty_act_d   = duty_q;
        end
      end
      RUN: begin
        if (!enable_q) begin
          state_d = IDLE;
          count_d = '0;
        end else if (wrap_c) begin
          count_d      = '0;
          period_act_d = period_q;
          duty_act_d   = duty_q;
        end else begin
          count_d = count_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    // Outputs are computed from next-cycle values so the flops line up with state/count.
    pwm_d  = (state_d == RUN) && (count_d < duty_act_d);
    pend_d = (state_d == RUN) &&
             ((period_act_d <= DW'(1)) || (count_d == period_act_d - DW'(1)));
  end

  // FSM, counter, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      period_act_q <= '0;
      duty_act_q   <= '0;
      pwm_out      <= 1'b0;
      period_end   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      pwm_out      <= pwm_d;
      period_end   <= pend_d;
    end
  end

endmodule

// File: tb/tb_pwm_bus_slave.sv
// Self-checking bench for pwm_bus_slave (BASE_ADDR = 0x10).
module tb_pwm_bus_slave;

  localparam logic [31:0] BASE     = 32'h10;
  localparam logic [31:0] REG_EN   = 32'h10;
  localparam logic [31:0] REG_PER  = 32'h14;
  localparam logic [31:0] REG_DUTY = 32'h18;
  localparam logic [31:0] REG_CNT  = 32'h1C;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        pwm_out;
  logic        period_end;

  int n_pass;
  int n_total;

  pwm_bus_slave #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adr        (adr),
    .cs         (cs),
    .wr         (wr),
    .rd         (rd),
    .d_in       (d_in),
    .d_out      (d_out),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_W, OP_R, OP_WR} op_t;
  typedef struct {
    op_t         op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_dout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    adr = a; d_in = d; cs = 1'b1; wr = 1'b1; rd = 1'b0;
    step();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    adr = a; cs = 1'b1; wr = 1'b0; rd = 1'b1;
    step();
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic bus_wrrd(input logic [31:0] a, input logic [31:0] d);
    adr = a; d_in = d; cs = 1'b1; wr = 1'b1; rd = 1'b1;
    step();
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  // Program and start from IDLE, then compare n cycles against the reference waveform.
  task automatic run_check(input logic [31:0] p, input logic [31:0] d, input int n,
                           input bit track_cnt, input string tag);
    logic [31:0] peff;
    logic [31:0] cnt;
    logic [31:0] prev;
    bus_write(REG_PER, p);
    bus_write(REG_DUTY, d);
    bus_write(REG_EN, 32'h3);
    if (track_cnt) begin
      adr = REG_CNT; cs = 1'b1; rd = 1'b1;
    end
    peff = (p == 0) ? 32'd1 : p;
    for (int i = 0; i < n; i++) begin
      step();
      cnt = 32'(i) % peff;
      chk($sformatf("%s pwm[%0d]", tag, i), {31'b0, pwm_out}, {31'b0, cnt < d});
      chk($sformatf("%s pend[%0d]", tag, i), {31'b0, period_end}, {31'b0, cnt == peff - 1});
      if (track_cnt) begin
        prev = (i == 0) ? 32'd0 : 32'(i - 1) % peff;
        chk($sformatf("%s count[%0d]", tag, i), d_out, prev);
      end
    end
    if (track_cnt) begin
      cs = 1'b0; rd = 1'b0;
    end
  endtask

  task automatic stop_check(input string tag);
    bus_write(REG_EN, 32'h0);
    step();
    chk({tag, " stop pwm"}, {31'b0, pwm_out}, 32'd0);
    chk({tag, " stop pend"}, {31'b0, period_end}, 32'd0);
  endtask

  vec_t vecs[18];

  initial begin
    n_pass = 0; n_total = 0;
    adr = '0; cs = 1'b0; wr = 1'b0; rd = 1'b0; d_in = '0;

    vecs[0]  = '{OP_W,  32'h00, 32'h1,         32'h0};
    vecs[1]  = '{OP_W,  32'h13, 32'h1,         32'h0};
    vecs[2]  = '{OP_W,  32'h1C, 32'h5,         32'h0};
    vecs[3]  = '{OP_W,  32'h14, 32'h1234_5678, 32'h0};
    vecs[4]  = '{OP_R,  32'h14, 32'h0,         32'h1234_5678};
    vecs[5]  = '{OP_R,  32'h10, 32'h0,         32'h0};
    vecs[6]  = '{OP_R,  32'h14, 32'h0,         32'h1234_5678};
    vecs[7]  = '{OP_R,  32'h1C, 32'h0,         32'h0};
    vecs[8]  = '{OP_W,  32'h18, 32'hA5,        32'h0};
    vecs[9]  = '{OP_R,  32'h18, 32'h0,         32'hA5};
    vecs[10] = '{OP_R,  32'h20, 32'h0,         32'h0};
    vecs[11] = '{OP_R,  32'h18, 32'h0,         32'hA5};
    vecs[12] = '{OP_R,  32'h17, 32'h0,         32'h0};
    vecs[13] = '{OP_R,  32'h18, 32'h0,         32'hA5};
    vecs[14] = '{OP_WR, 32'h14, 32'h99,        32'hA5};
    vecs[15] = '{OP_R,  32'h14, 32'h0,         32'h99};
    vecs[16] = '{OP_W,  32'h10, 32'hFFFF_FFFE, 32'h99};
    vecs[17] = '{OP_R,  32'h10, 32'h0,         32'h0};

    // Reset and idle
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(); step();
    chk("rst d_out", d_out, 32'h0);
    chk("rst pwm", {31'b0, pwm_out}, 32'd0);
    chk("rst pend", {31'b0, period_end}, 32'd0);
    rst_n = 1'b1;
    step();
    bus_read(REG_EN);   chk("rst rd en",   d_out, 32'h0);
    bus_read(REG_PER);  chk("rst rd per",  d_out, 32'h0);
    bus_read(REG_DUTY); chk("rst rd duty", d_out, 32'h0);
    bus_read(REG_CNT);  chk("rst rd cnt",  d_out, 32'h0);

    // Bus decode table
    for (int i = 0; i < 18; i++) begin
      case (vecs[i].op)
        OP_W:    bus_write(vecs[i].a, vecs[i].d);
        OP_R:    bus_read(vecs[i].a);
        default: bus_wrrd(vecs[i].a, vecs[i].d);
      endcase
      chk($sformatf("decode[%0d]", i), d_out, vecs[i].exp_dout);
      chk($sformatf("decode[%0d] idle pwm", i), {31'b0, pwm_out}, 32'd0);
    end

    // Basic PWM with COUNT tracking; ends in the count-9 cycle of the second period
    run_check(32'd10, 32'd3, 20, 1'b1, "basic");
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("pre-upd pwm[%0d]", k), {31'b0, pwm_out}, {31'b0, k < 3});
    end

    // Buffered DUTY update written during count 4; applies from the next wrap
    bus_write(REG_DUTY, 32'd7);
    for (int k = 5; k < 25; k++) begin
      chk($sformatf("upd pwm[%0d]", k), {31'b0, pwm_out},
          {31'b0, (k % 10) < ((k < 10) ? 3 : 7)});
      chk($sformatf("upd pend[%0d]", k), {31'b0, period_end}, {31'b0, (k % 10) == 9});
      step();
    end

    // Stop in the middle of the high phase (count 5 of a duty-7 period)
    chk("pre-stop pwm high", {31'b0, pwm_out}, 32'd1);
    stop_check("midhigh");
    bus_read(REG_CNT);
    chk("stop count", d_out, 32'h0);

    // Edge duties and periods, each a re-enable from IDLE
    run_check(32'd10, 32'd0, 12, 1'b0, "d0");    stop_check("d0");
    run_check(32'd10, 32'd10, 12, 1'b0, "d10");  stop_check("d10");
    run_check(32'd10, 32'd15, 12, 1'b0, "d15");  stop_check("d15");
    run_check(32'd0, 32'd5, 6, 1'b0, "p0");      stop_check("p0");
    run_check(32'd4, 32'd1, 8, 1'b0, "reen");    stop_check("reen");

    // Asynchronous reset in the middle of a high phase
    run_check(32'd10, 32'd5, 2, 1'b0, "prerst");
    bus_read(REG_EN);
    chk("en readback", d_out, 32'h1);
    chk("prerst pwm high", {31'b0, pwm_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst pwm", {31'b0, pwm_out}, 32'd0);
    chk("async rst pend", {31'b0, period_end}, 32'd0);
    chk("async rst d_out", d_out, 32'h0);
    #10 rst_n = 1'b1;
    step();
    bus_read(REG_EN);   chk("post rst en",   d_out, 32'h0);
    bus_read(REG_PER);  chk("post rst per",  d_out, 32'h0);
    bus_read(REG_DUTY); chk("post rst duty", d_out, 32'h0);
    bus_read(REG_CNT);  chk("post rst cnt",  d_out, 32'h0);
    chk("post rst pwm", {31'b0, pwm_out}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
